// File: rtl/mem_pkg.sv
// Shared types and lane helpers for the handshaked data memory.
// Size encodings, FSM state enum and byte-lane helper functions.
package mem_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'd0,
        SZ_HALF = 2'd1,
        SZ_WORD = 2'd2,
        SZ_ILL  = 2'd3
    } mem_size_e;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StBusy = 2'd1,
        StResp = 2'd2
    } mem_state_e;

    typedef struct packed {
        logic        we;
        mem_size_e   size;
        logic        uns;
        logic [31:0] addr;
        logic [31:0] wdata;
    } mem_req_t;

    function automatic logic [3:0] lane_enables(mem_size_e size, logic [1:0] lo);
        logic [3:0] be;
        be = 4'b0000;
        unique case (size)
            SZ_BYTE: be = 4'b0001 << lo;
            SZ_HALF: be = 4'b0011 << {lo[1], 1'b0};
            SZ_WORD: be = 4'b1111;
            default: be = 4'b0000;
        endcase
        return be;
    endfunction

    // Right-aligned store data replicated so every enabled lane sees its bytes.
    function automatic logic [31:0] lane_wdata(mem_size_e size, logic [31:0] wdata);
        logic [31:0] res;
        res = wdata;
        unique case (size)
            SZ_BYTE: res = {4{wdata[7:0]}};
            SZ_HALF: res = {2{wdata[15:0]}};
            default: res = wdata;
        endcase
        return res;
    endfunction

    function automatic logic size_misaligned(mem_size_e size, logic [1:0] lo);
        logic bad;
        bad = 1'b1;
        unique case (size)
            SZ_BYTE: bad = 1'b0;
            SZ_HALF: bad = lo[0];
            SZ_WORD: bad = (lo != 2'b00);
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

    function automatic logic [31:0] load_extend(mem_size_e size, logic uns, logic [1:0] lo,
                                                logic [31:0] word);
        logic [31:0] sh;
        logic [31:0] res;
        sh  = word >> {lo, 3'b000};
        res = '0;
        unique case (size)
            SZ_BYTE: res = uns ? {24'd0, sh[7:0]} : {{24{sh[7]}}, sh[7:0]};
            SZ_HALF: res = uns ? {16'd0, sh[15:0]} : {{16{sh[15]}}, sh[15:0]};
            SZ_WORD: res = word;
            default: res = '0;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/data_memory_ram.sv
// Word-organised RAM: byte-enable synchronous write, asynchronous read.
// Contents start at zero and are never touched by reset.
module data_memory_ram #(
    parameter int unsigned DEPTH = 1024,
    parameter int unsigned AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [3:0]    be,
    input  logic [AW-1:0] addr,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);

    logic [31:0] mem_q [DEPTH] = '{default: 32'd0};

    always_ff @(posedge clk) begin
        if (we) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) begin
                    mem_q[addr][8*i +: 8] <= wdata[8*i +: 8];
                end
            end
        end
    end

    assign rdata = mem_q[addr];

endmodule

// File: rtl/data_memory_hs.sv
// Valid/ready data memory with fixed response latency. A request accepted in cycle c
// is answered from cycle c+LATENCY; the RAM access happens on the edge entering RESP.
module data_memory_hs
    import mem_pkg::*;
#(
    parameter int unsigned DEPTH   = 1024,
    parameter int unsigned LATENCY = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err
);

    localparam int unsigned AW       = $clog2(DEPTH);
    localparam logic [3:0]  BusyLast = 4'((LATENCY > 1) ? LATENCY - 2 : 0);

    mem_state_e  state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    mem_req_t    req_q, req_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;

    mem_req_t      cur_req;
    mem_req_t      eff_req;
    logic          accept;
    logic          enter_resp;
    logic          addr_err;
    logic          ram_we;
    logic [3:0]    ram_be;
    logic [AW-1:0] ram_addr;
    logic [31:0]   ram_wdata;
    logic [31:0]   ram_rdata;

    always_comb begin
        cur_req.we    = req_we;
        cur_req.size  = mem_size_e'(req_size);
        cur_req.uns   = req_unsigned;
        cur_req.addr  = req_addr;
        cur_req.wdata = req_wdata;
    end

    assign accept = req_valid && (state_q == StIdle);

    // With LATENCY = 1 the access happens on the accept edge, so use the live request.
    assign eff_req = (state_q == StIdle) ? cur_req : req_q;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        enter_resp = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (req_valid) begin
                    cnt_d = '0;
                    if (LATENCY == 1) begin
                        state_d    = StResp;
                        enter_resp = 1'b1;
                    end else begin
                        state_d = StBusy;
                    end
                end
            end
            StBusy: begin
                if (cnt_q == BusyLast) begin
                    state_d    = StResp;
                    enter_resp = 1'b1;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            StResp: begin
                if (resp_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Outputs
    always_comb begin
        req_ready  = (state_q == StIdle);
        resp_valid = (state_q == StResp);
        resp_rdata = rdata_q;
        resp_err   = err_q;
    end

    assign addr_err = size_misaligned(eff_req.size, eff_req.addr[1:0]) ||
                      ((eff_req.addr >> 2) >= 32'(DEPTH));

    assign ram_addr  = eff_req.addr[AW+1:2];
    assign ram_be    = lane_enables(eff_req.size, eff_req.addr[1:0]);
    assign ram_wdata = lane_wdata(eff_req.size, eff_req.wdata);
    // rst_n gate keeps a LATENCY = 1 request presented during reset from committing.
    assign ram_we    = rst_n && enter_resp && eff_req.we && !addr_err;

    always_comb begin
        req_d   = accept ? cur_req : req_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        if (enter_resp) begin
            err_d   = addr_err;
            rdata_d = (addr_err || eff_req.we) ? 32'd0 :
                      load_extend(eff_req.size, eff_req.uns, eff_req.addr[1:0], ram_rdata);
        end else if ((state_q == StResp) && resp_ready) begin
            err_d   = 1'b0;
            rdata_d = 32'd0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_q   <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            req_q   <= req_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    data_memory_ram #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .be    (ram_be),
        .addr  (ram_addr),
        .wdata (ram_wdata),
        .rdata (ram_rdata)
    );

endmodule

// File: tb/tb_data_memory_hs.sv
// Bench for data_memory_hs: four instances with LATENCY 2, 1, 4 and 3 sharing one clock.
module tb_data_memory_hs;

    localparam int NDUT  = 4;
    localparam int DEPTH = 64;

    logic        clk = 1'b0;
    logic        rst_n        [NDUT];
    logic        req_valid    [NDUT];
    logic        req_ready    [NDUT];
    logic        req_we       [NDUT];
    logic [1:0]  req_size     [NDUT];
    logic        req_unsigned [NDUT];
    logic [31:0] req_addr     [NDUT];
    logic [31:0] req_wdata    [NDUT];
    logic        resp_valid   [NDUT];
    logic        resp_ready   [NDUT];
    logic [31:0] resp_rdata   [NDUT];
    logic        resp_err     [NDUT];

    always #5 clk = ~clk;

    for (genvar g = 0; g < NDUT; g++) begin : g_dut
        data_memory_hs #(
            .DEPTH   (DEPTH),
            .LATENCY ((g == 0) ? 2 : (g == 1) ? 1 : (g == 2) ? 4 : 3)
        ) u_dut (
            .clk          (clk),
            .rst_n        (rst_n[g]),
            .req_valid    (req_valid[g]),
            .req_ready    (req_ready[g]),
            .req_we       (req_we[g]),
            .req_size     (req_size[g]),
            .req_unsigned (req_unsigned[g]),
            .req_addr     (req_addr[g]),
            .req_wdata    (req_wdata[g]),
            .resp_valid   (resp_valid[g]),
            .resp_ready   (resp_ready[g]),
            .resp_rdata   (resp_rdata[g]),
            .resp_err     (resp_err[g])
        );
    end

    typedef struct {
        int          dut;
        logic        we;
        logic [1:0]  size;
        logic        uns;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_err;
        int          hold;
    } vec_t;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    exp_t sb[$];
    vec_t vecs[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    function automatic int lat_of(int d);
        case (d)
            0:       return 2;
            1:       return 1;
            2:       return 4;
            default: return 3;
        endcase
    endfunction

    function automatic vec_t mk(int d, logic we, logic [1:0] sz, logic u, logic [31:0] a,
                                logic [31:0] w, logic [31:0] er, logic ee, int hold);
        vec_t v;
        v.dut = d; v.we = we; v.size = sz; v.uns = u; v.addr = a; v.wdata = w;
        v.exp_rdata = er; v.exp_err = ee; v.hold = hold;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outs(input int d, input string tag);
        check({tag, "_req_ready"}, 32'(req_ready[d]), 32'd1);
        check({tag, "_resp_valid"}, 32'(resp_valid[d]), 32'd0);
        check({tag, "_resp_rdata"}, resp_rdata[d], 32'd0);
        check({tag, "_resp_err"}, 32'(resp_err[d]), 32'd0);
    endtask

    task automatic drive(input int d, input logic we, input logic [1:0] sz, input logic u,
                         input logic [31:0] a, input logic [31:0] w);
        req_valid[d] = 1'b1; req_we[d] = we; req_size[d] = sz;
        req_unsigned[d] = u; req_addr[d] = a; req_wdata[d] = w;
    endtask

    task automatic release_req(input int d);
        req_valid[d] = 1'b0;
        req_we[d]    = 1'($urandom);
        req_addr[d]  = $urandom;
        req_wdata[d] = $urandom;
    endtask

    // Returns number of cycles from the accept cycle until resp_valid (bounded).
    task automatic wait_resp(input int d, output int k);
        k = 1;
        while (resp_valid[d] !== 1'b1 && k < 20) begin
            step();
            k++;
        end
    endtask

    task automatic run_req(input vec_t v);
        int   d;
        int   k;
        exp_t e;
        d = v.dut;
        k = 0;
        while (req_ready[d] !== 1'b1 && k < 50) begin
            step();
            k++;
        end
        check("req_ready_idle", 32'(req_ready[d]), 32'd1);
        drive(d, v.we, v.size, v.uns, v.addr, v.wdata);
        sb.push_back('{v.exp_rdata, v.exp_err});
        step();
        release_req(d);
        wait_resp(d, k);
        check("latency", 32'(k), 32'(lat_of(d)));
        if (sb.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL scoreboard: got empty queue expected an entry");
            e = '{32'd0, 1'b0};
        end else begin
            e = sb.pop_front();
        end
        for (int h = 0; h <= v.hold; h++) begin
            check("resp_valid_held", 32'(resp_valid[d]), 32'd1);
            check("resp_rdata", resp_rdata[d], e.rdata);
            check("resp_err", 32'(resp_err[d]), 32'(e.err));
            check("req_ready_in_resp", 32'(req_ready[d]), 32'd0);
            if (h == v.hold) resp_ready[d] = 1'b1;
            step();
        end
        resp_ready[d] = 1'b0;
        check("resp_valid_after_hs", 32'(resp_valid[d]), 32'd0);
        check("req_ready_after_hs", 32'(req_ready[d]), 32'd1);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        for (int d = 0; d < NDUT; d++) begin
            rst_n[d] = 1'b0;
            release_req(d);
            req_size[d] = 2'd2;
            req_unsigned[d] = 1'b0;
            resp_ready[d] = 1'b0;
        end
        step();
        step();
        for (int d = 0; d < NDUT; d++) check_reset_outs(d, "por");
        for (int d = 0; d < NDUT; d++) rst_n[d] = 1'b1;
        step();

        // dut, we, size, uns, addr, wdata, exp_rdata, exp_err, hold
        vecs.push_back(mk(0, 1, 2, 0, 32'h10, 32'hDEADBEEF, 32'h0,        0, 0));
        vecs.push_back(mk(0, 0, 2, 0, 32'h10, 32'h0,        32'hDEADBEEF, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 32'h13, 32'h0,        32'hFFFFFFDE, 0, 0));
        vecs.push_back(mk(0, 0, 0, 1, 32'h13, 32'h0,        32'h000000DE, 0, 0));
        vecs.push_back(mk(0, 0, 1, 0, 32'h10, 32'h0,        32'hFFFFBEEF, 0, 0));
        vecs.push_back(mk(0, 0, 1, 1, 32'h12, 32'h0,        32'h0000DEAD, 0, 0));
        vecs.push_back(mk(0, 1, 0, 0, 32'h11, 32'hFFFFFF55, 32'h0,        0, 0));
        vecs.push_back(mk(0, 0, 2, 0, 32'h10, 32'h0,        32'hDEAD55EF, 0, 5));
        vecs.push_back(mk(0, 0, 2, 0, 32'h12, 32'h0,        32'h0,        1, 0));
        vecs.push_back(mk(0, 1, 1, 0, 32'h21, 32'h1234,     32'h0,        1, 0));
        vecs.push_back(mk(0, 1, 3, 0, 32'h10, 32'hFFFFFFFF, 32'h0,        1, 0));
        vecs.push_back(mk(0, 0, 3, 1, 32'h10, 32'h0,        32'h0,        1, 0));
        vecs.push_back(mk(0, 1, 2, 0, DEPTH * 4, 32'h12345678, 32'h0,     1, 0));
        vecs.push_back(mk(0, 0, 2, 0, DEPTH * 4, 32'h0,     32'h0,        1, 0));
        vecs.push_back(mk(0, 0, 2, 0, 32'h20, 32'h0,        32'h0,        0, 0));
        vecs.push_back(mk(0, 0, 2, 0, 32'h10, 32'h0,        32'hDEAD55EF, 0, 0));
        vecs.push_back(mk(0, 1, 1, 0, 32'h22, 32'hABCD8001, 32'h0,        0, 0));
        vecs.push_back(mk(0, 0, 2, 0, 32'h20, 32'h0,        32'h80010000, 0, 0));
        vecs.push_back(mk(0, 0, 1, 0, 32'h22, 32'h0,        32'hFFFF8001, 0, 0));
        vecs.push_back(mk(0, 0, 0, 1, 32'h23, 32'h0,        32'h00000080, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 32'h22, 32'h0,        32'h00000001, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 32'h10, 32'h0,        32'hFFFFFFEF, 0, 0));
        vecs.push_back(mk(1, 1, 2, 0, 32'h4,  32'h0BADF00D, 32'h0,        0, 5));
        vecs.push_back(mk(1, 0, 2, 0, 32'h4,  32'h0,        32'h0BADF00D, 0, 5));
        vecs.push_back(mk(1, 0, 0, 1, 32'h5,  32'h0,        32'h000000F0, 0, 0));
        vecs.push_back(mk(2, 1, 2, 0, 32'h4,  32'h0BADF00D, 32'h0,        0, 0));
        vecs.push_back(mk(2, 0, 2, 0, 32'h4,  32'h0,        32'h0BADF00D, 0, 5));
        vecs.push_back(mk(2, 0, 2, 0, 32'h6,  32'h0,        32'h0,        1, 5));
        vecs.push_back(mk(2, 0, 1, 0, 32'h6,  32'h0,        32'h00000BAD, 0, 0));
        vecs.push_back(mk(3, 1, 2, 0, 32'h8,  32'h11112222, 32'h0,        0, 0));

        foreach (vecs[i]) run_req(vecs[i]);

        // Reset one cycle after a store is accepted: the store must never commit.
        drive(3, 1'b1, 2'd2, 1'b0, 32'h8, 32'h33334444);
        step();
        release_req(3);
        step();
        rst_n[3] = 1'b0;
        #1;
        check_reset_outs(3, "rst_busy");
        step();
        check_reset_outs(3, "rst_busy_edge");
        rst_n[3] = 1'b1;
        step();
        run_req(mk(3, 0, 2, 0, 32'h8, 32'h0, 32'h11112222, 0, 0));

        // Reset while a store response is pending: the store is already in memory.
        drive(3, 1'b1, 2'd2, 1'b0, 32'hC, 32'h000000AA);
        step();
        release_req(3);
        wait_resp(3, k);
        check("rst_resp_latency", 32'(k), 32'd3);
        rst_n[3] = 1'b0;
        #1;
        check_reset_outs(3, "rst_resp");
        step();
        rst_n[3] = 1'b1;
        step();
        run_req(mk(3, 0, 2, 0, 32'hC, 32'h0, 32'h000000AA, 0, 0));
        run_req(mk(3, 0, 0, 0, 32'hA, 32'h0, 32'h00000011, 0, 0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
